// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the digit-serial multiplier result collector.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_t;

    // Default geometry: P=2 digit width, 16-bit maximum operands.
    localparam int P_DEFAULT         = 2;
    localparam int MAX_WIDTH_DEFAULT = 16;
    localparam int DIGITS_MAX        = 2 * MAX_WIDTH_DEFAULT / P_DEFAULT;
    localparam int CNT_W             = $clog2(DIGITS_MAX) + 1;

    // Working width of the sign-extension helper; callers zero-extend into it
    // and truncate the result back to their own bus width.
    localparam int SEXT_W = 256;

    // Replicate bit (n_digits*p_bits - 1) of data_i into every higher bit.
    function automatic logic [SEXT_W-1:0] sign_extend(
        input logic [SEXT_W-1:0] data_i,
        input int unsigned       n_digits,
        input int unsigned       p_bits
    );
        logic [SEXT_W-1:0] ext;
        int                msb;
        msb = int'(n_digits * p_bits) - 1;
        ext = data_i;
        for (int i = 0; i < SEXT_W; i++) begin
            if (i > msb) begin
                ext[i] = data_i[msb];
            end else begin
                ext[i] = data_i[i];
            end
        end
        return ext;
    endfunction

endpackage

// File: rtl/programmable_counter.sv
// Counter with synchronous clear and a terminal-count flag.
// UPDOWN=0: counts up from 0, last_o when count equals count_set_i.
// UPDOWN=1: loads count_set_i on clear, counts down, last_o at 0.
module programmable_counter #(
    parameter int W      = 5,
    parameter int UPDOWN = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] count_set_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    logic [W-1:0] count_q;

    // Count register: clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= (UPDOWN != 0) ? count_set_i : '0;
        end else if (en_i) begin
            count_q <= (UPDOWN != 0) ? (count_q - W'(1)) : (count_q + W'(1));
        end
    end

    assign count_o = count_q;
    assign last_o  = (UPDOWN != 0) ? (count_q == '0) : (count_q == count_set_i);

endmodule

// File: rtl/seq_mult_collector.sv
// Collects LSB-first product digits from the digit-serial multiplier, builds
// the signed product, sign-extends it to 2*MAX_WIDTH and holds it on a
// valid/ready interface. Flags overflow, short streams and illegal sizes.
module seq_mult_collector
    import seq_mult_pkg::*;
#(
    parameter int P         = 2,
    parameter int MAX_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_WIDTH/P):0]  bitSize,
    input  logic [P-1:0]                  digit_i,
    input  logic                          digit_valid_i,
    input  logic                          done_i,
    output logic [2*MAX_WIDTH-1:0]        result_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          short_o,
    output logic                          bad_size_o
);

    localparam int BS_W  = $clog2(MAX_WIDTH / P) + 1;
    localparam int SLOTS = 2 * MAX_WIDTH / P;
    localparam int CW    = $clog2(SLOTS) + 1;
    localparam int RES_W = 2 * MAX_WIDTH;

    collector_state_t state_q;
    logic [BS_W-1:0]  bitsize_q;
    logic [RES_W-1:0] buffer_q;
    logic [RES_W-1:0] buffer_d;
    logic [RES_W-1:0] result_q;
    logic [RES_W-1:0] result_d;
    logic             result_valid_q;
    logic             busy_q;
    logic             overflow_q;
    logic             short_q;
    logic             bad_size_q;

    logic [CW-1:0]    n_s;
    logic [CW-1:0]    count_set_s;
    logic [CW-1:0]    cnt_s;
    logic             last_s;
    logic             cnt_en_s;
    logic             size_ok_s;

    // N = 2*bitSize digits; the counter flags slot N-1 as the final digit.
    assign n_s         = {bitsize_q, 1'b0};
    assign count_set_s = n_s - CW'(1);
    assign cnt_en_s    = digit_valid_i & (state_q == COLLECT) & ~start;
    assign size_ok_s   = (bitSize != '0) && (bitSize <= BS_W'(MAX_WIDTH / P));

    programmable_counter #(
        .W      (CW),
        .UPDOWN (0)
    ) u_digit_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start),
        .en_i        (cnt_en_s),
        .count_set_i (count_set_s),
        .count_o     (cnt_s),
        .last_o      (last_s)
    );

    // Slot write for the incoming digit and the sign-extended view of the result.
    always_comb begin
        buffer_d = buffer_q;
        for (int k = 0; k < SLOTS; k++) begin
            buffer_d[k*P +: P] = (cnt_en_s && (cnt_s == CW'(k))) ? digit_i : buffer_q[k*P +: P];
        end
        result_d = RES_W'(sign_extend(SEXT_W'(buffer_d), 32'(n_s), 32'(P)));
    end

    // Collector FSM with registered result, handshake and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bitsize_q      <= '0;
            buffer_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            short_q        <= 1'b0;
            bad_size_q     <= 1'b0;
        end else begin
            bad_size_q <= 1'b0;
            if (start) begin
                result_valid_q <= 1'b0;
                if (!size_ok_s) begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    bad_size_q <= 1'b1;
                end else begin
                    state_q    <= COLLECT;
                    busy_q     <= 1'b1;
                    bitsize_q  <= bitSize;
                    buffer_q   <= '0;
                    overflow_q <= 1'b0;
                    short_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (digit_valid_i) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        buffer_q <= buffer_d;
                        if (digit_valid_i && last_s) begin
                            state_q        <= HOLD;
                            result_q       <= result_d;
                            result_valid_q <= 1'b1;
                            busy_q         <= 1'b0;
                        end else if (done_i) begin
                            // Stream ended early: deliver what arrived, missing slots zero.
                            state_q        <= HOLD;
                            result_q       <= result_d;
                            result_valid_q <= 1'b1;
                            busy_q         <= 1'b0;
                            short_q        <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (digit_valid_i) begin
                            overflow_q <= 1'b1;
                        end
                        if (result_ready_i) begin
                            state_q        <= IDLE;
                            result_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign overflow_o     = overflow_q;
    assign short_o        = short_q;
    assign bad_size_o     = bad_size_q;

endmodule
